// File: rtl/coeff_loader_if.sv
// Byte-stream input and coefficient RAM write port of the coefficient loader.
interface coeff_loader_if #(
    parameter int COEFF_NBITS = 32
);
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   ram_we;
    logic [4:0]             ram_addr;
    logic [COEFF_NBITS-1:0] ram_d;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, ram_we, ram_addr, ram_d
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, ram_we, ram_addr, ram_d
    );
endinterface

// File: rtl/coeff_loader.sv
// Assembles a checksummed, framed byte stream into coefficient words
// and writes them to consecutive RAM addresses.
module coeff_loader #(
    parameter int         COEFF_NBITS    = 32,
    parameter int         NCOEFFS        = 30,
    parameter logic [7:0] HDR_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rstn,
    coeff_loader_if.slave bus,
    output logic       load_busy,
    output logic       load_done,
    output logic       load_err,
    output logic       coeff_valid
);
    localparam int NBYTES = (COEFF_NBITS + 7) / 8;
    localparam int SW     = NBYTES * 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, CSUM, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   rdy_q;
    logic [SW-1:0]          sh_q;
    logic [BW-1:0]          bidx_q;
    logic [4:0]             widx_q;
    logic [7:0]             sum_q;
    logic [TW-1:0]          timer_q;
    logic                   we_q;
    logic [4:0]             addr_q;
    logic [COEFF_NBITS-1:0] d_q;
    logic                   err_q;
    logic                   valid_q;

    logic          acc;
    logic          is_hdr;
    logic          last_byte;
    logic          last_word;
    logic          tmo;
    logic          cs_ok;
    logic [SW-1:0] shifted;

    assign bus.byte_ready = rdy_q && (state_q != DONE);
    assign bus.ram_we     = we_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_d      = d_q;
    assign load_busy      = (state_q != IDLE);
    assign load_done      = (state_q == DONE);
    assign load_err       = err_q;
    assign coeff_valid    = valid_q;

    assign acc       = bus.byte_valid && bus.byte_ready;
    assign is_hdr    = acc && (bus.byte_data == HDR_BYTE);
    assign last_byte = (bidx_q == BW'(NBYTES - 1));
    assign last_word = (widx_q == 5'(NCOEFFS - 1));
    assign tmo       = !acc && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign cs_ok     = (bus.byte_data == sum_q);
    // MSB-first: unused top bits of the first byte fall off the word slice
    assign shifted   = (sh_q << 8) | SW'(bus.byte_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (is_hdr) state_d = DATA;
            DATA: begin
                if (tmo)
                    state_d = DONE;
                else if (acc && last_byte && last_word)
                    state_d = CSUM;
            end
            CSUM: if (tmo || acc) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q   <= 1'b0;
            sh_q    <= '0;
            bidx_q  <= '0;
            widx_q  <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            we_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (is_hdr) begin
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                        widx_q  <= '0;
                        bidx_q  <= '0;
                        sum_q   <= '0;
                        timer_q <= '0;
                        sh_q    <= '0;
                    end
                end
                DATA: begin
                    if (acc) begin
                        sh_q    <= shifted;
                        sum_q   <= sum_q + bus.byte_data;
                        timer_q <= '0;
                        if (last_byte) begin
                            bidx_q <= '0;
                            we_q   <= 1'b1;
                            addr_q <= widx_q;
                            d_q    <= shifted[COEFF_NBITS-1:0];
                            // index stays on the last word so it never wraps
                            if (!last_word)
                                widx_q <= widx_q + 5'd1;
                        end else begin
                            bidx_q <= bidx_q + BW'(1);
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                        if (tmo) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end
                    end
                end
                CSUM: begin
                    if (acc) begin
                        timer_q <= '0;
                        err_q   <= !cs_ok;
                        valid_q <= cs_ok;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                        if (tmo) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/coeff_loader.md
# coeff_loader

Upstream feeder for the crossover's coefficient dual-port RAM. It receives a framed byte stream from the host-interface byte receiver and assembles the bytes into coefficient words. Each completed word is written into the RAM write port at consecutive addresses. It validates the frame with a checksum and an inter-byte timeout, and reports load status to the control logic that gates filter operation.

## Interface

**Parameters**

- COEFF_NBITS, 32, coefficient word width; must match the RAM data width
- NCOEFFS, 30, words per frame; 1..32
- HDR_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 65535, maximum clk cycles allowed between bytes inside a frame

**Ports**

- clk  in  1  system clock
- rstn  in  1  reset; asynchronous assert, active-low
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  incoming byte
- byte_ready  out  1  a byte is accepted when byte_valid && byte_ready
- ram_we  out  1  RAM write strobe, one-cycle pulse per word
- ram_addr  out  5  RAM write address
- ram_d  out  COEFF_NBITS  RAM write data
- load_busy  out  1  frame in progress (state != IDLE)
- load_done  out  1  one-cycle pulse at the end of every frame, good or bad
- load_err  out  1  last frame failed (checksum or timeout); sticky until the next header
- coeff_valid  out  1  RAM holds a complete, checksum-verified coefficient set

## Operation

- NBYTES = ceil(COEFF_NBITS/8). Data bytes arrive MSB-first. The word is the low COEFF_NBITS bits of the NBYTES*8-bit shift register, so unused top bits of the first byte are ignored.
- Frame format: HDR_BYTE, then NCOEFFS*NBYTES data bytes, then 1 checksum byte. The checksum byte equals the 8-bit modulo-256 sum of the data bytes only.
- **IDLE**
  - byte_ready=1.
  - Non-header bytes are accepted and discarded.
  - HDR_BYTE: clear load_err, coeff_valid, word index, byte index, sum and timer; go to DATA.
- **DATA**
  - byte_ready=1.
  - Each accepted byte is shifted into the word register and added to the sum.
  - On the NBYTES-th byte of a word: the next cycle drives ram_we=1, ram_addr=word index, ram_d=assembled word; the word index then increments.
  - After the last byte of word NCOEFFS-1: go to CSUM.
  - A byte equal to HDR_BYTE is treated as data; there is no resync.
- **CSUM**
  - byte_ready=1.
  - Accepted byte equal to sum: coeff_valid=1, load_err=0.
  - Mismatch: load_err=1, coeff_valid=0.
  - Either way go to DONE.
- **DONE**
  - byte_ready=0.
  - load_done=1 for this single cycle; return to IDLE.
- **Timeout**
  - In DATA or CSUM, the timer counts cycles with no accepted byte and is cleared on each accepted byte.
  - Timer reaching TIMEOUT_CYCLES: load_err=1, coeff_valid=0, go to DONE.
  - Words already written stay in RAM; coeff_valid=0 marks the set as unusable.
- Because coeff_valid drops at the header, downstream filters see invalid coefficients for the whole duration of a reload.

## Timing

- Reset values (rstn=0, asynchronous): state=IDLE, byte_ready=0 while rstn=0, ram_we=0, ram_addr=0, ram_d=0, load_busy=0, load_done=0, load_err=0, coeff_valid=0.
- byte_ready is 1 from the first clk edge after rstn deasserts.
- ram_we is registered: asserted exactly 1 cycle after the accepting edge of a word's last byte, and never asserted outside DATA/CSUM.
- Back-to-back bytes (byte_valid held high) are accepted at 1 byte/cycle with no stalls except the DONE cycle.
- The final word's ram_we coincides with the first CSUM cycle. A checksum byte accepted in that same cycle is legal.
- load_done is asserted 1 cycle after the checksum byte is accepted, or 1 cycle after the timeout hit.
- load_err and coeff_valid update in the same cycle that load_done asserts.
- ram_addr never exceeds NCOEFFS-1; the word index does not wrap within a frame.
- rstn asserted mid-frame: immediate return to reset values. A partial frame leaves the RAM contents undefined for the consumer, and coeff_valid=0 indicates this.

## Test plan

- **Good frame.** NCOEFFS=30, NBYTES=4. Send A5, 120 bytes with word k = 32'h0100_0000*k + k, then the correct checksum, back-to-back. Required: 30 ram_we pulses at addr 0..29 with the matching data; load_done pulse; coeff_valid=1, load_err=0; a DONE cycle with byte_ready=0.
- **Bad checksum.** Same frame with checksum+1. Required: 30 writes, then load_done with load_err=1, coeff_valid=0.
- **Timeout.** TIMEOUT_CYCLES=16. Send A5 plus 10 bytes, then idle 20 cycles. Required: exactly 2 ram_we (addr 0, 1); load_done in the cycle after the timer reaches 16; load_err=1; return to IDLE.
- **Resync and garbage.** Send 00 FF 3C before A5, and a frame containing A5 as a data byte. Required: pre-header bytes ignored; the in-frame A5 is stored as data; checksum passes.
- **Reload.** After a good load, send a new header. Required: coeff_valid drops the cycle after the header is accepted and returns to 1 only after the second good checksum.
- **Reset mid-frame.** Assert rstn=0 after 50 data bytes. Required: all outputs at reset values asynchronously; a subsequent full frame loads correctly from addr 0.
